// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide sequencer.
//   - md_op encodings (mult, multu, div, divu)
//   - sequencer state enum (IDLE, RUN)
//   - default busy latencies and latency counter width
//   - HI/LO select encoding used by mthi/mtlo
package mdu_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Latencies are legal in 1..15, so a 4-bit down-counter suffices.
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int          CNT_W           = 4;

  localparam logic HILO_SEL_LO = 1'b0;
  localparam logic HILO_SEL_HI = 1'b1;

  // Bit 1 of md_op distinguishes the divide class from the multiply class.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// mdu_compute: purely combinational arithmetic for the multiply/divide unit.
// Kept separate so it can later be replaced by an iterative divider.
// Ports:
//   md_op       in   2  operation select (MD_MULT/MD_MULTU/MD_DIV/MD_DIVU)
//   rs_val      in  32  rs operand (multiplicand / dividend)
//   rt_val      in  32  rt operand (multiplier / divisor)
//   hi64_result out 64  {HI, LO} result: product, or {remainder, quotient}
//   div0        out  1  divide op with rt_val == 0 (result must not commit)
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] hi64_result,
  output logic        div0
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic        [31:0] quot_s;
  logic        [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               sdiv_ovf;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Substitute a harmless divisor on zero so the dividers never see x/0;
  // the result is discarded anyway because div0 blocks the commit.
  assign divisor  = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign div0     = is_div_op(md_op) && (rt_val == 32'd0);

  // -2^31 / -1 does not fit in 32 bits; pin the architectural result.
  assign sdiv_ovf = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    if (sdiv_ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else begin
      // SystemVerilog signed / truncates toward zero and % takes the
      // dividend's sign, which is exactly the required semantics.
      quot_s = $signed(rs_val) / $signed(divisor);
      rem_s  = $signed(rs_val) % $signed(divisor);
    end
  end

  assign quot_u = rs_val / divisor;
  assign rem_u  = rs_val % divisor;

  always_comb begin
    hi64_result = 64'd0;
    case (md_op)
      MD_MULT:  hi64_result = prod_s;
      MD_MULTU: hi64_result = prod_u;
      MD_DIV:   hi64_result = {rem_s, quot_s};
      MD_DIVU:  hi64_result = {rem_u, quot_u};
      default:  hi64_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning the HI/LO registers.
// An accepted mult/div holds the unit busy for a fixed latency, then commits
// HI/LO (unless the op was a divide by zero). Raises a stall request while
// a HI/LO-class instruction sits in D and the unit is starting or busy.
// Ports:
//   clk         in   1  pipeline clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   start       in   1  E-stage mult/multu/div/divu (single-cycle pulse)
//   md_op       in   2  operation, sampled with start
//   rs_val      in  32  forwarded rs operand
//   rt_val      in  32  forwarded rt operand
//   hilo_we     in   1  mthi/mtlo write enable
//   hilo_sel    in   1  0 = LO, 1 = HI
//   hilo_wdata  in  32  mthi/mtlo data
//   is_md_D     in   1  D-stage instruction touches the mult/div unit or HI/LO
//   busy        out  1  operation in flight
//   stall_md    out  1  stall request to pipeline control
//   hi          out 32  committed HI
//   lo          out 32  committed LO
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,  // legal 1..15
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF    // legal 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] hilo_wdata,
  input  logic        is_md_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  mdu_state_e        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic              div0_q,    div0_d;
  logic [31:0]       hi_q,      hi_d;
  logic [31:0]       lo_q,      lo_d;

  logic [63:0]       calc_result;
  logic              calc_div0;

  mdu_compute u_compute (
    .md_op       (md_op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .hi64_result (calc_result),
    .div0        (calc_div0)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        // start has priority over a same-cycle mthi/mtlo.
        if (start) begin
          pend_hi_d = calc_result[63:32];
          pend_lo_d = calc_result[31:0];
          div0_d    = calc_div0;
          cnt_d     = is_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
          state_d   = ST_RUN;
        end else if (hilo_we) begin
          if (hilo_sel == HILO_SEL_HI) begin
            hi_d = hilo_wdata;
          end else begin
            lo_d = hilo_wdata;
          end
        end
      end

      ST_RUN: begin
        // start/hilo_we here are protocol violations and are ignored.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!div0_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  // Combinational so the stall covers the start cycle itself.
  assign stall_md = is_md_D & (start | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
